// File: rtl/syst_pkg.sv
// Shared definitions for the systolic array edge blocks: default widths,
// the drain FSM state type and the common round-and-saturate helper.
package syst_pkg;

   localparam int DEF_N_ROWS  = 8;
   localparam int DEF_S_WIDTH = 32;
   localparam int DEF_O_WIDTH = 16;
   localparam int DEF_SHIFT   = 15;

   // Working width of sat_round; callers sign-extend into it (S_WIDTH <= 63).
   localparam int SR_WIDTH = 64;

   typedef enum logic {
      IDLE,
      SEND
   } drain_state_e;

   // Arithmetic shift right with round half up, then clamp to a signed o_width range.
   // The extra guard bit keeps the rounding add from wrapping for any input.
   function automatic logic signed [SR_WIDTH-1:0] sat_round(
      input logic signed [SR_WIDTH-1:0] value,
      input int                         shift,
      input int                         o_width
   );
      logic signed [SR_WIDTH:0]   one;
      logic signed [SR_WIDTH:0]   ext;
      logic signed [SR_WIDTH:0]   rounded;
      logic signed [SR_WIDTH:0]   max_v;
      logic signed [SR_WIDTH:0]   min_v;
      logic signed [SR_WIDTH-1:0] result;
      one = {{SR_WIDTH{1'b0}}, 1'b1};
      ext = {value[SR_WIDTH-1], value};
      if (shift > 0) begin
         rounded = (ext + (one <<< (shift - 1))) >>> shift;
      end else begin
         rounded = ext;
      end
      max_v = (one <<< (o_width - 1)) - one;
      min_v = -(one <<< (o_width - 1));
      if (rounded > max_v) begin
         result = max_v[SR_WIDTH-1:0];
      end else if (rounded < min_v) begin
         result = min_v[SR_WIDTH-1:0];
      end else begin
         result = rounded[SR_WIDTH-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/syst_sat_round.sv
// Combinational round-and-saturate stage narrowing an S_WIDTH partial sum
// to an O_WIDTH output word.
module syst_sat_round
   import syst_pkg::*;
#(
   parameter int S_WIDTH = DEF_S_WIDTH,
   parameter int O_WIDTH = DEF_O_WIDTH,
   parameter int SHIFT   = DEF_SHIFT
) (
   input  logic signed [S_WIDTH-1:0] value_i,
   output logic signed [O_WIDTH-1:0] value_o
);

   assign value_o = O_WIDTH'(sat_round(SR_WIDTH'(value_i), SHIFT, O_WIDTH));

endmodule

// File: rtl/syst_out_collector.sv
// Collects the skewed last-node results of each systolic row into ping-pong
// frame banks and drains each full frame as a rounded, saturated word stream.
module syst_out_collector
   import syst_pkg::*;
#(
   parameter int N_ROWS    = DEF_N_ROWS,
   parameter int S_WIDTH   = DEF_S_WIDTH,
   parameter int O_WIDTH   = DEF_O_WIDTH,
   parameter int SHIFT     = DEF_SHIFT,
   parameter int IDX_WIDTH = $clog2(N_ROWS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [N_ROWS*S_WIDTH-1:0]  psumm_i,
   input  logic [N_ROWS-1:0]          valid_i,
   output logic signed [O_WIDTH-1:0]  data_o,
   output logic [IDX_WIDTH-1:0]       idx_o,
   output logic                       last_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   input  logic                       clear_err_i,
   output logic                       overflow_o,
   output logic                       collision_o
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_ROWS - 1);
   localparam logic [N_ROWS-1:0]    ALL_ROWS = '1;

   logic signed [S_WIDTH-1:0] bank_mem [2][N_ROWS];
   logic [1:0]                bank_full;
   logic [1:0]                bank_full_next;
   logic [N_ROWS-1:0]         got;
   logic [N_ROWS-1:0]         cap_mask;
   logic                      wr_bank;
   logic                      rd_bank;
   logic [IDX_WIDTH-1:0]      idx;
   drain_state_e              state;

   logic                      complete;
   logic                      free_now;
   logic                      fill_rd;
   logic                      fill_other;
   logic                      coll_now;
   logic                      ovf_now;
   logic signed [S_WIDTH-1:0] rd_word;
   logic signed [O_WIDTH-1:0] sat_word;

   // Only a free write bank accepts rows, so a completion can never land on
   // the bank being freed by the drain side in the same cycle.
   always_comb begin
      cap_mask = '0;
      if (enable && !bank_full[wr_bank]) begin
         cap_mask = valid_i & ~got;
      end
      complete   = ((got | cap_mask) == ALL_ROWS);
      coll_now   = enable && |(valid_i & got);
      ovf_now    = enable && bank_full[wr_bank] && |valid_i;
      free_now   = valid_o && ready_i && last_o;
      fill_rd    = complete && (wr_bank == rd_bank);
      fill_other = complete && (wr_bank != rd_bank);

      bank_full_next = bank_full;
      if (free_now) begin
         bank_full_next[rd_bank] = 1'b0;
      end
      if (complete) begin
         bank_full_next[wr_bank] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < N_ROWS; k++) begin
         if (cap_mask[k]) begin
            bank_mem[wr_bank][k] <= psumm_i[k*S_WIDTH +: S_WIDTH];
         end
      end
   end

   // Sticky errors: a new error in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_full   <= '0;
         got         <= '0;
         wr_bank     <= 1'b0;
         overflow_o  <= 1'b0;
         collision_o <= 1'b0;
      end else begin
         bank_full   <= bank_full_next;
         got         <= complete ? '0 : (got | cap_mask);
         if (complete) begin
            wr_bank <= ~wr_bank;
         end
         overflow_o  <= (overflow_o & ~clear_err_i) | ovf_now;
         collision_o <= (collision_o & ~clear_err_i) | coll_now;
      end
   end

   // Completions are looked at directly so the first word follows the
   // completing capture by one cycle and back-to-back frames need no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         idx     <= '0;
         rd_bank <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bank_full[rd_bank] || fill_rd) begin
                  state   <= SEND;
                  valid_o <= 1'b1;
               end
            end
            SEND: begin
               if (valid_o && ready_i) begin
                  if (last_o) begin
                     rd_bank <= ~rd_bank;
                     idx     <= '0;
                     last_o  <= 1'b0;
                     if (bank_full[!rd_bank] || fill_other) begin
                        valid_o <= 1'b1;
                     end else begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                     end
                  end else begin
                     idx    <= idx + 1'b1;
                     last_o <= ((idx + 1'b1) == LAST_IDX);
                  end
               end
            end
            default: begin
               state   <= IDLE;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

   assign rd_word = bank_mem[rd_bank][idx];

   syst_sat_round #(
      .S_WIDTH (S_WIDTH),
      .O_WIDTH (O_WIDTH),
      .SHIFT   (SHIFT)
   ) u_sat_round (
      .value_i (rd_word),
      .value_o (sat_word)
   );

   assign data_o = valid_o ? sat_word : '0;
   assign idx_o  = idx;

endmodule

// File: tb/tb_syst_out_collector.sv
// Directed bench for syst_out_collector with 4 rows, 32-bit sums, 16-bit words, shift 4.
module tb_syst_out_collector;

   logic                clk = 1'b0;
   logic                rst;
   logic                enable;
   logic [127:0]        psumm;
   logic [3:0]          valid_i;
   logic signed [15:0]  data_o;
   logic [1:0]          idx_o;
   logic                last_o;
   logic                valid_o;
   logic                ready_i;
   logic                clear_err_i;
   logic                overflow_o;
   logic                collision_o;

   int checks   = 0;
   int failures = 0;

   syst_out_collector #(
      .N_ROWS  (4),
      .S_WIDTH (32),
      .O_WIDTH (16),
      .SHIFT   (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .psumm_i     (psumm),
      .valid_i     (valid_i),
      .data_o      (data_o),
      .idx_o       (idx_o),
      .last_o      (last_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .clear_err_i (clear_err_i),
      .overflow_o  (overflow_o),
      .collision_o (collision_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one row for one cycle; called right after a falling edge.
   task automatic send_row(input int k, input logic signed [31:0] v);
      psumm[k*32 +: 32] = v;
      valid_i = 4'b0000;
      valid_i[k] = 1'b1;
      @(negedge clk);
      valid_i = 4'b0000;
   endtask

   task automatic send_frame(input logic signed [31:0] v0, input logic signed [31:0] v1,
                             input logic signed [31:0] v2, input logic signed [31:0] v3);
      psumm = {v3, v2, v1, v0};
      valid_i = 4'b1111;
      @(negedge clk);
      valid_i = 4'b0000;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b1;
      psumm = '0;
      valid_i = '0;
      ready_i = 1'b1;
      clear_err_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
      checks++; if (data_o !== 16'sd0) begin failures++; $display("[TB] FAIL reset_data: got %0d expected 0", data_o); end
      checks++; if (last_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_last: got %b expected 0", last_o); end
      checks++; if (idx_o !== 2'd0) begin failures++; $display("[TB] FAIL reset_idx: got %0d expected 0", idx_o); end
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_o); end
      checks++; if (collision_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_collision: got %b expected 0", collision_o); end
   endtask

   task automatic test_skewed_frame();
      logic signed [15:0] exp_d [4];
      exp_d[0] = 16'sd16; exp_d[1] = 16'sd32; exp_d[2] = -16'sd16; exp_d[3] = 16'sd0;
      ready_i = 1'b1;
      send_row(0, 32'sh100);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL skew_early_valid: got %b expected 0", valid_o); end
      send_row(1, 32'sh200);
      send_row(2, -32'sh100);
      send_row(3, 32'sh7);
      for (int i = 0; i < 4; i++) begin
         checks++; if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL skew_valid[%0d]: got %b expected 1", i, valid_o); end
         checks++; if (idx_o !== 2'(i)) begin failures++; $display("[TB] FAIL skew_idx[%0d]: got %0d expected %0d", i, idx_o, i); end
         checks++; if (data_o !== exp_d[i]) begin failures++; $display("[TB] FAIL skew_data[%0d]: got %0d expected %0d", i, data_o, exp_d[i]); end
         checks++; if (last_o !== (i == 3)) begin failures++; $display("[TB] FAIL skew_last[%0d]: got %b expected %b", i, last_o, (i == 3)); end
         @(negedge clk);
      end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL skew_end_valid: got %b expected 0", valid_o); end
      checks++; if (data_o !== 16'sd0) begin failures++; $display("[TB] FAIL skew_end_data: got %0d expected 0", data_o); end
   endtask

   task automatic test_saturation();
      logic signed [15:0] exp_d [4];
      exp_d[0] = 16'sh7FFF; exp_d[1] = -16'sh8000; exp_d[2] = 16'sd2; exp_d[3] = -16'sd1;
      ready_i = 1'b1;
      send_frame(32'sh0010_0000, -32'sh0010_0000, 32'sh18, -32'sh18);
      for (int i = 0; i < 4; i++) begin
         checks++; if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL sat_valid[%0d]: got %b expected 1", i, valid_o); end
         checks++; if (data_o !== exp_d[i]) begin failures++; $display("[TB] FAIL sat_data[%0d]: got %0d expected %0d", i, data_o, exp_d[i]); end
         @(negedge clk);
      end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL sat_end_valid: got %b expected 0", valid_o); end
   endtask

   task automatic test_back_to_back();
      logic signed [31:0] b_rows [4];
      logic signed [15:0] exp_d [8];
      b_rows[0] = 32'sh50; b_rows[1] = 32'sh60; b_rows[2] = 32'sh70; b_rows[3] = 32'sh80;
      for (int i = 0; i < 8; i++) exp_d[i] = 16'(i + 1);
      ready_i = 1'b0;
      send_frame(32'sh10, 32'sh20, 32'sh30, 32'sh40);
      for (int c = 0; c < 20; c++) begin
         checks++;
         if (valid_o !== 1'b1 || idx_o !== 2'd0 || data_o !== 16'sd1 || last_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold[%0d]: got valid=%b idx=%0d data=%0d last=%b expected valid=1 idx=0 data=1 last=0",
                     c, valid_o, idx_o, data_o, last_o);
         end
         if (c < 4) begin
            psumm[c*32 +: 32] = b_rows[c];
            valid_i = 4'(1 << c);
         end else begin
            valid_i = 4'b0000;
         end
         @(negedge clk);
      end
      valid_i = 4'b0000;
      ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, valid_o); end
         checks++; if (idx_o !== 2'(i % 4)) begin failures++; $display("[TB] FAIL b2b_idx[%0d]: got %0d expected %0d", i, idx_o, i % 4); end
         checks++; if (data_o !== exp_d[i]) begin failures++; $display("[TB] FAIL b2b_data[%0d]: got %0d expected %0d", i, data_o, exp_d[i]); end
         checks++; if (last_o !== (i % 4 == 3)) begin failures++; $display("[TB] FAIL b2b_last[%0d]: got %b expected %b", i, last_o, (i % 4 == 3)); end
         @(negedge clk);
      end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end_valid: got %b expected 0", valid_o); end
   endtask

   task automatic test_overflow();
      logic signed [15:0] exp_d [8];
      for (int i = 0; i < 8; i++) exp_d[i] = 16'(i + 1);
      ready_i = 1'b0;
      send_frame(32'sh10, 32'sh20, 32'sh30, 32'sh40);
      send_frame(32'sh50, 32'sh60, 32'sh70, 32'sh80);
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_before: got %b expected 0", overflow_o); end
      send_frame(32'sh1000, 32'sh2000, 32'sh3000, 32'sh4000);
      checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow_o); end
      checks++; if (collision_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_no_collision: got %b expected 0", collision_o); end
      ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL ovf_valid[%0d]: got %b expected 1", i, valid_o); end
         checks++; if (data_o !== exp_d[i]) begin failures++; $display("[TB] FAIL ovf_data[%0d]: got %0d expected %0d", i, data_o, exp_d[i]); end
         @(negedge clk);
      end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_dropped_frame: got valid=%b expected 0", valid_o); end
      checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_o); end
      clear_err_i = 1'b1;
      @(negedge clk);
      clear_err_i = 1'b0;
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow_o); end
   endtask

   task automatic test_collision();
      logic signed [15:0] exp_d [4];
      exp_d[0] = 16'sd1; exp_d[1] = 16'sd5; exp_d[2] = 16'sd2; exp_d[3] = 16'sd3;
      ready_i = 1'b1;
      send_row(0, 32'sh10);
      send_row(1, 32'sh50);
      checks++; if (collision_o !== 1'b0) begin failures++; $display("[TB] FAIL coll_early: got %b expected 0", collision_o); end
      send_row(1, 32'sh60);
      checks++; if (collision_o !== 1'b1) begin failures++; $display("[TB] FAIL coll_set: got %b expected 1", collision_o); end
      send_row(2, 32'sh20);
      send_row(3, 32'sh30);
      for (int i = 0; i < 4; i++) begin
         checks++; if (idx_o !== 2'(i)) begin failures++; $display("[TB] FAIL coll_idx[%0d]: got %0d expected %0d", i, idx_o, i); end
         checks++; if (data_o !== exp_d[i]) begin failures++; $display("[TB] FAIL coll_data[%0d]: got %0d expected %0d", i, data_o, exp_d[i]); end
         @(negedge clk);
      end
      clear_err_i = 1'b1;
      @(negedge clk);
      clear_err_i = 1'b0;
      checks++; if (collision_o !== 1'b0) begin failures++; $display("[TB] FAIL coll_clear: got %b expected 0", collision_o); end
      // A collision arriving together with the clear must leave the flag set.
      send_row(0, 32'sh10);
      clear_err_i = 1'b1;
      send_row(0, 32'sh20);
      clear_err_i = 1'b0;
      checks++; if (collision_o !== 1'b1) begin failures++; $display("[TB] FAIL coll_set_wins: got %b expected 1", collision_o); end
      send_row(1, 32'sh10);
      send_row(2, 32'sh10);
      send_row(3, 32'sh10);
      repeat (5) @(negedge clk);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL coll_flush_valid: got %b expected 0", valid_o); end
   endtask

   task automatic test_reset_mid_drain();
      ready_i = 1'b0;
      send_frame(32'sh10, 32'sh20, 32'sh30, 32'sh40);
      send_frame(32'sh50, 32'sh60, 32'sh70, 32'sh80);
      ready_i = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (idx_o !== 2'd2) begin failures++; $display("[TB] FAIL rmd_idx_before: got %0d expected 2", idx_o); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rmd_valid: got %b expected 0", valid_o); end
      checks++; if (data_o !== 16'sd0) begin failures++; $display("[TB] FAIL rmd_data: got %0d expected 0", data_o); end
      checks++; if (collision_o !== 1'b0) begin failures++; $display("[TB] FAIL rmd_collision: got %b expected 0", collision_o); end
      repeat (3) @(negedge clk);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rmd_banks_empty: got valid=%b expected 0", valid_o); end
      send_frame(32'sh90, 32'shA0, 32'shB0, 32'shC0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL rmd_fresh_valid[%0d]: got %b expected 1", i, valid_o); end
         checks++; if (idx_o !== 2'(i)) begin failures++; $display("[TB] FAIL rmd_fresh_idx[%0d]: got %0d expected %0d", i, idx_o, i); end
         checks++; if (data_o !== 16'(i + 9)) begin failures++; $display("[TB] FAIL rmd_fresh_data[%0d]: got %0d expected %0d", i, data_o, i + 9); end
         @(negedge clk);
      end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rmd_end_valid: got %b expected 0", valid_o); end
   endtask

   initial begin
      test_reset();
      test_skewed_frame();
      test_saturation();
      test_back_to_back();
      test_overflow();
      test_collision();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
